// File: rtl/add_1bit_serial_ctrl_if.sv
// Host and adder-side bundle for the bit-serial add sequencer; optional carry pins via ADD_SERIAL_CARRY_EN.
// Latency: pure wiring, no storage.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface add_1bit_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ADD_SERIAL_CARRY_EN
    logic             cin;
    logic             cout;
`endif
    logic             add_a;
    logic             add_b;
    logic             add_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             busy;

    // Controller side
    modport slave (
        input  in_valid,
        input  a,
        input  b,
`ifdef ADD_SERIAL_CARRY_EN
        input  cin,
        output cout,
`endif
        input  add_c,
        input  out_ready,
        output in_ready,
        output add_a,
        output add_b,
        output out_valid,
        output sum,
        output busy
    );

    // Host plus 1-bit adder side
    modport master (
        output in_valid,
        output a,
        output b,
`ifdef ADD_SERIAL_CARRY_EN
        output cin,
        input  cout,
`endif
        output add_c,
        output out_ready,
        input  in_ready,
        input  add_a,
        input  add_b,
        input  out_valid,
        input  sum,
        input  busy
    );
endinterface

// File: rtl/add_1bit_serial_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer around an external XOR-only 1-bit adder; ADD_SERIAL_CARRY_EN adds cin/cout.
// Latency: accept at edge k, out_valid high after edge k+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; DONE holds sum/cout indefinitely until out_ready.
module add_1bit_serial_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    add_1bit_serial_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             sum_bit_d;
    logic             carry_d;
`ifdef ADD_SERIAL_CARRY_EN
    logic             cout_q;
    logic             carry_init;
    assign carry_init = bus.cin;
    assign bus.cout   = cout_q;
`else
    logic             carry_init;
    assign carry_init = 1'b0;
`endif

    // The external adder only provides a^b; the carry chain lives here.
    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.add_a     = (state_q == RUN) && a_sr_q[0];
    assign bus.add_b     = (state_q == RUN) && b_sr_q[0];
    assign sum_bit_d     = bus.add_c ^ carry_q;
    assign carry_d       = (bus.add_a & bus.add_b) | (carry_q & bus.add_c);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.busy      = busy_q;

    // Sequencer: load operands, shift one bit per cycle LSB first, hold result until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADD_SERIAL_CARRY_EN
            cout_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr_q  <= bus.a;
                        b_sr_q  <= bus.b;
                        carry_q <= carry_init;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Right shift: after WIDTH shifts bit i sits in sum_q[i].
                    sum_q   <= {sum_bit_d, sum_q[WIDTH-1:1]};
                    carry_q <= carry_d;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
`ifdef ADD_SERIAL_CARRY_EN
                        cout_q      <= carry_d;
`endif
                    end
                end
                DONE: begin
                    // Handoff back to IDLE costs a cycle, so in_ready stays low here.
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_1bit_serial_ctrl.sv
// Directed bench for the bit-serial add sequencer, WIDTH = 8; covers cin/cout when ADD_SERIAL_CARRY_EN is defined.
// Latency: expects out_valid after the 8th edge following accept, results 10 cycles apart back-to-back.
// Backpressure: holds out_ready low in DONE and checks the result is held and no new op is accepted.
module tb_add_1bit_serial_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    add_1bit_serial_ctrl_if #(.WIDTH(W)) bus ();

    add_1bit_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // The fabric 1-bit adder: XOR only, combinational.
    assign bus.add_c = bus.add_a ^ bus.add_b;

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair at a negedge in IDLE, check the bit stream and
    // latency, and return at the negedge after the result appears (state DONE).
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic [7:0] exp_sum, input logic exp_cout);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
`ifdef ADD_SERIAL_CARRY_EN
        bus.cin      = ci;
`else
        if (ci) $display("note: %s carry-in ignored in this build", tag);
`endif
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        for (int i = 0; i < W; i++) begin
            chk($sformatf("%s_add_a%0d", tag, i), 32'(bus.add_a), 32'(av[i]));
            chk($sformatf("%s_add_b%0d", tag, i), 32'(bus.add_b), 32'(bv[i]));
            chk($sformatf("%s_nvld%0d", tag, i), 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
`ifdef ADD_SERIAL_CARRY_EN
        chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
`else
        if (exp_cout) $display("note: %s carry-out dropped in this build", tag);
`endif
    endtask

    logic [7:0] pa[3]   = '{8'h01, 8'h80, 8'h7F};
    logic [7:0] pb[3]   = '{8'h02, 8'h80, 8'h01};
    logic [7:0] psum[3] = '{8'h03, 8'h00, 8'h80};
    logic       pco[3]  = '{1'b0, 1'b1, 1'b0};

    initial begin
        int         idx_in;
        int         idx_out;
        int         last_cyc;
        logic       pending;
        logic [7:0] held;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b1;
`ifdef ADD_SERIAL_CARRY_EN
        bus.cin       = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_add_a", 32'(bus.add_a), 32'd0);
        chk("rst_add_b", 32'(bus.add_b), 32'd0);
`ifdef ADD_SERIAL_CARRY_EN
        chk("rst_cout", 32'(bus.cout), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 1. zero operands, 2. basic add, 3. carry and wrap
        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("zero_idle_vld", 32'(bus.out_valid), 32'd0);
        chk("zero_idle_rdy", 32'(bus.in_ready), 32'd1);
        chk("zero_idle_busy", 32'(bus.busy), 32'd0);
        run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        @(negedge clk);
        run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
`ifdef ADD_SERIAL_CARRY_EN
        run_op("cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        @(negedge clk);
`endif

        // 4. back-pressure: result held, second request ignored
        bus.out_ready = 1'b0;
        run_op("bp", 8'h21, 8'h43, 1'b0, 8'h64, 1'b0);
        held         = bus.sum;
        bus.in_valid = 1'b1;
        bus.a        = 8'h11;
        bus.b        = 8'h22;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("bp_vld%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_sum%0d", i), 32'(bus.sum), 32'h64);
            chk($sformatf("bp_rdy%0d", i), 32'(bus.in_ready), 32'd0);
        end
        chk("bp_sum_held", 32'(bus.sum), 32'(held));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_vld", 32'(bus.out_valid), 32'd0);
        chk("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
        chk("bp_rel_busy", 32'(bus.busy), 32'd0);

        // 5. reset at RUN bit 3
        bus.in_valid = 1'b1;
        bus.a        = 8'h10;
        bus.b        = 8'h20;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum", 32'(bus.sum), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_add_a", 32'(bus.add_a), 32'd0);
        chk("mid_rst_add_b", 32'(bus.add_b), 32'd0);
        chk("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("mid_novld%0d", i), 32'(bus.out_valid), 32'd0);
        end
        run_op("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        @(negedge clk);

        // 6. back-to-back with in_valid and out_ready held high
        idx_in       = 0;
        idx_out      = 0;
        last_cyc     = 0;
        bus.in_valid = 1'b1;
        bus.a        = pa[0];
        bus.b        = pb[0];
        pending      = bus.in_ready;
        for (int cyc = 0; cyc < 60 && idx_out < 3; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk($sformatf("b2b_sum%0d", idx_out), 32'(bus.sum), 32'(psum[idx_out]));
`ifdef ADD_SERIAL_CARRY_EN
                chk($sformatf("b2b_cout%0d", idx_out), 32'(bus.cout), 32'(pco[idx_out]));
`else
                if (pco[idx_out]) $display("note: b2b op %0d overflows", idx_out);
`endif
                if (idx_out > 0)
                    chk($sformatf("b2b_gap%0d", idx_out), 32'(cyc - last_cyc), 32'd10);
                last_cyc = cyc;
                idx_out++;
            end
            if (pending) begin
                idx_in++;
                if (idx_in < 3) begin
                    bus.a = pa[idx_in];
                    bus.b = pb[idx_in];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            pending = bus.in_ready && bus.in_valid;
        end
        chk("b2b_count", 32'(idx_out), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
